// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: RV32 opcode constants, ECALL sequencer states
// and the default ABI register/code used for the halt convention.
package cpu_pkg;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

    localparam int unsigned DEF_ARG_REG   = 17;
    localparam int unsigned DEF_HALT_CODE = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ecall_state_e;

    function automatic logic is_ecall_insn(input logic [31:0] insn);
        return insn == ECALL_INSN;
    endfunction

endpackage

// File: rtl/arg_forward_mux.sv
// Combinational operand resolution for one architectural register: EX/MEM
// forwarding first, then MEM/WB, then the register file. x0 never matches.
module arg_forward_mux #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_IDX = 17
) (
    input  logic            i_ex_write,
    input  logic            i_ex_load,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_data,
    input  logic            i_wb_write,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic [XLEN-1:0] i_rf_data,
    output logic [XLEN-1:0] o_value,
    output logic            o_not_ready
);

    logic w_ex_hit;
    logic w_wb_hit;

    assign w_ex_hit = i_ex_write & (i_ex_rd != 5'd0) & (i_ex_rd == 5'(REG_IDX));
    assign w_wb_hit = i_wb_write & (i_wb_rd != 5'd0) & (i_wb_rd == 5'(REG_IDX));

    always_comb begin
        o_value     = i_rf_data;
        o_not_ready = 1'b0;
        if (w_ex_hit) begin
            o_value     = i_ex_data;
            // A load in EX/MEM has no data yet; the caller must stall.
            o_not_ready = i_ex_load;
        end else if (w_wb_hit) begin
            o_value = i_wb_data;
        end
    end

endmodule

// File: rtl/ecall_halt_unit.sv
// ECALL handler beside the hazard unit: resolves a7, issues ordinary system
// calls, or flushes and drains the pipeline before raising a sticky halt.
module ecall_halt_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ARG_REG      = DEF_ARG_REG,
    parameter int unsigned HALT_CODE    = DEF_HALT_CODE,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_valid,
    input  logic             id_ex_is_ecall,
    input  logic             ex_mem_reg_write,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_rd,
    input  logic [XLEN-1:0]  ex_mem_alu_out,
    input  logic             mem_wb_reg_write,
    input  logic [4:0]       mem_wb_rd,
    input  logic [XLEN-1:0]  mem_wb_wdata,
    input  logic [XLEN-1:0]  rf_arg,
    output logic             ecall_stall,
    output logic             flush_younger,
    output logic             halt_pending,
    output logic             is_halted,
    output logic             syscall_pulse,
    output logic [XLEN-1:0]  syscall_code,
    output logic [CNT_W-1:0] syscall_count
);

    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    ecall_state_e    r_state;
    ecall_state_e    w_state_nxt;
    logic [DW-1:0]   r_drain_cnt;
    logic [DW-1:0]   w_drain_nxt;
    logic [XLEN-1:0] w_arg;
    logic            w_not_ready;
    logic            w_ecall;
    logic            w_decide;
    logic            w_halt_dec;
    logic            w_sys_dec;

    logic             r_flush;
    logic             r_pulse;
    logic [XLEN-1:0]  r_code;
    logic [CNT_W-1:0] r_count;

    arg_forward_mux #(
        .XLEN    (XLEN),
        .REG_IDX (ARG_REG)
    ) u_arg_mux (
        .i_ex_write  (ex_mem_reg_write),
        .i_ex_load   (ex_mem_mem_read),
        .i_ex_rd     (ex_mem_rd),
        .i_ex_data   (ex_mem_alu_out),
        .i_wb_write  (mem_wb_reg_write),
        .i_wb_rd     (mem_wb_rd),
        .i_wb_data   (mem_wb_wdata),
        .i_rf_data   (rf_arg),
        .o_value     (w_arg),
        .o_not_ready (w_not_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_ecall     = 1'b0;
        ecall_stall = 1'b0;
        w_decide    = 1'b0;
        w_halt_dec  = 1'b0;
        w_sys_dec   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A stalled ECALL stays in ID/EX and is decided on its first clean cycle.
                w_ecall     = id_ex_valid & id_ex_is_ecall;
                ecall_stall = w_ecall & w_not_ready;
                w_decide    = w_ecall & ~w_not_ready;
                w_halt_dec  = w_decide & (w_arg == XLEN'(HALT_CODE));
                w_sys_dec   = w_decide & ~w_halt_dec;
                if (w_halt_dec) begin
                    w_state_nxt = DRAIN;
                    w_drain_nxt = DW'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_drain_nxt = r_drain_cnt - DW'(1);
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush <= 1'b0;
            r_pulse <= 1'b0;
            r_code  <= '0;
            r_count <= '0;
        end else begin
            r_flush <= w_halt_dec;
            r_pulse <= w_sys_dec;
            if (w_sys_dec) begin
                r_code <= w_arg;
                if (r_count != '1) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign flush_younger = r_flush;
    assign syscall_pulse = r_pulse;
    assign syscall_code  = r_code;
    assign syscall_count = r_count;
    assign halt_pending  = (r_state == DRAIN);
    assign is_halted     = (r_state == HALTED);

endmodule

// File: tb/tb_ecall_halt_unit.sv
// Bench for ecall_halt_unit: directed table, hand-built multi-cycle sequences
// and a randomized run against a cycle-count based reference model.
module tb_ecall_halt_unit;

    localparam int unsigned ARG   = 17;
    localparam int unsigned HALT  = 10;
    localparam int unsigned DRAIN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ex_valid, id_ex_is_ecall;
    logic        ex_mem_reg_write, ex_mem_mem_read;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] ex_mem_alu_out, mem_wb_wdata, rf_arg;
    logic        mem_wb_reg_write;

    logic        stall_a, flush_a, pend_a, halt_a, pulse_a;
    logic [31:0] code_a;
    logic [15:0] count_a;
    logic        stall_b, flush_b, pend_b, halt_b, pulse_b;
    logic [31:0] code_b;
    logic [1:0]  count_b;

    always #5 clk = ~clk;

    ecall_halt_unit #(.XLEN(32), .ARG_REG(ARG), .HALT_CODE(HALT), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .id_ex_is_ecall(id_ex_is_ecall),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .ex_mem_alu_out(ex_mem_alu_out), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_wdata(mem_wb_wdata), .rf_arg(rf_arg), .ecall_stall(stall_a), .flush_younger(flush_a),
        .halt_pending(pend_a), .is_halted(halt_a), .syscall_pulse(pulse_a), .syscall_code(code_a),
        .syscall_count(count_a));

    ecall_halt_unit #(.XLEN(32), .ARG_REG(ARG), .HALT_CODE(HALT), .DRAIN_CYCLES(DRAIN), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .id_ex_valid(id_ex_valid), .id_ex_is_ecall(id_ex_is_ecall),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .ex_mem_alu_out(ex_mem_alu_out), .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .mem_wb_wdata(mem_wb_wdata), .rf_arg(rf_arg), .ecall_stall(stall_b), .flush_younger(flush_b),
        .halt_pending(pend_b), .is_halted(halt_b), .syscall_pulse(pulse_b), .syscall_code(code_b),
        .syscall_count(count_b));

    typedef struct {
        logic        v, e, exw, exl;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd, rf;
        logic        xs, xf, xp;
        logic [31:0] xc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: halt tracked as the cycle index of the decision.
    int          cyc;
    int          halt_at;
    logic [31:0] m_code;
    int          m_cnt16, m_cnt2;
    bit          m_pulse;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, e, exw, exl, input logic [4:0] exrd, input logic [31:0] exd,
                                input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd, rf,
                                input logic xs, xf, xp, input logic [31:0] xc);
        vec_t r;
        r.v = v; r.e = e; r.exw = exw; r.exl = exl; r.exrd = exrd; r.exd = exd;
        r.wbw = wbw; r.wbrd = wbrd; r.wbd = wbd; r.rf = rf;
        r.xs = xs; r.xf = xf; r.xp = xp; r.xc = xc;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        id_ex_valid = t.v; id_ex_is_ecall = t.e;
        ex_mem_reg_write = t.exw; ex_mem_mem_read = t.exl; ex_mem_rd = t.exrd; ex_mem_alu_out = t.exd;
        mem_wb_reg_write = t.wbw; mem_wb_rd = t.wbrd; mem_wb_wdata = t.wbd; rf_arg = t.rf;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0));
    endtask

    function automatic void resolve(output bit nr, output logic [31:0] val);
        nr = 0;
        if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == ARG) begin
            nr = ex_mem_mem_read; val = ex_mem_alu_out;
        end else if (mem_wb_reg_write && mem_wb_rd != 0 && mem_wb_rd == ARG) begin
            val = mem_wb_wdata;
        end else begin
            val = rf_arg;
        end
    endfunction

    task automatic model_reset();
        cyc = 0; halt_at = -1; m_code = 0; m_cnt16 = 0; m_cnt2 = 0; m_pulse = 0;
    endtask

    task automatic model_edge();
        bit nr;
        logic [31:0] val;
        m_pulse = 0;
        if (halt_at < 0 && id_ex_valid && id_ex_is_ecall) begin
            resolve(nr, val);
            if (!nr) begin
                if (val == HALT) halt_at = cyc + 1;
                else begin
                    m_pulse = 1; m_code = val;
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_stall();
        bit nr;
        logic [31:0] val;
        bit exp;
        resolve(nr, val);
        exp = (halt_at < 0) && id_ex_valid && id_ex_is_ecall && nr;
        chk("stall_a", stall_a, exp);
        chk("stall_b", stall_b, exp);
    endtask

    task automatic check_regs();
        int since = cyc - halt_at;
        bit busy  = (halt_at >= 0);
        chk("flush_a", flush_a, busy && since == 0);
        chk("pending_a", pend_a, busy && since < DRAIN);
        chk("halted_a", halt_a, busy && since >= DRAIN);
        chk("pulse_a", pulse_a, m_pulse);
        chk("code_a", code_a, m_code);
        chk("count_a", 32'(count_a), m_cnt16);
        chk("flush_b", flush_b, busy && since == 0);
        chk("halted_b", halt_b, busy && since >= DRAIN);
        chk("pulse_b", pulse_b, m_pulse);
        chk("count_b", 32'(count_b), m_cnt2);
    endtask

    // Starts and ends at a falling edge; inputs must already be driven.
    task automatic tick();
        #1 check_stall();
        @(posedge clk);
        model_edge();
        #1 check_regs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        #1;
        chk("rst_stall", stall_a, 0);
        chk("rst_flush", flush_a, 0);
        chk("rst_pending", pend_a, 0);
        chk("rst_halted", halt_a, 0);
        chk("rst_pulse", pulse_a, 0);
        chk("rst_code", code_a, 0);
        chk("rst_count", 32'(count_a), 0);
        chk("rst_count_b", 32'(count_b), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t tbl[10];
    int   pulses;

    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        do_reset();

        //      v  e  exw exl exrd   exd     wbw wbrd   wbd     rf      xs xf xp xc
        tbl[0] = mk(1, 1, 1, 0, 5'd17, 32'd10, 0, 5'd0,  32'd0,  32'd3,  0, 1, 0, 32'd0);
        tbl[1] = mk(1, 1, 1, 1, 5'd17, 32'd10, 0, 5'd0,  32'd0,  32'd3,  1, 0, 0, 32'd0);
        tbl[2] = mk(1, 1, 1, 0, 5'd17, 32'd5,  1, 5'd17, 32'd10, 32'd3,  0, 0, 1, 32'd5);
        tbl[3] = mk(1, 1, 0, 0, 5'd0,  32'd0,  0, 5'd0,  32'd0,  32'd10, 0, 1, 0, 32'd0);
        tbl[4] = mk(1, 1, 1, 0, 5'd0,  32'd10, 0, 5'd0,  32'd0,  32'd4,  0, 0, 1, 32'd4);
        tbl[5] = mk(1, 1, 1, 0, 5'd5,  32'd3,  1, 5'd17, 32'd10, 32'd2,  0, 1, 0, 32'd0);
        tbl[6] = mk(0, 1, 0, 0, 5'd0,  32'd0,  0, 5'd0,  32'd0,  32'd10, 0, 0, 0, 32'd0);
        tbl[7] = mk(1, 0, 1, 1, 5'd17, 32'd10, 0, 5'd0,  32'd0,  32'd10, 0, 0, 0, 32'd0);
        tbl[8] = mk(1, 1, 0, 1, 5'd17, 32'd10, 0, 5'd0,  32'd0,  32'd3,  0, 0, 1, 32'd3);
        tbl[9] = mk(1, 1, 0, 0, 5'd0,  32'd0,  0, 5'd17, 32'd10, 32'd8,  0, 0, 1, 32'd8);

        foreach (tbl[i]) begin
            do_reset();
            drive(tbl[i]);
            #1 chk($sformatf("tbl%0d_stall", i), stall_a, tbl[i].xs);
            tick();
            chk($sformatf("tbl%0d_flush", i), flush_a, tbl[i].xf);
            chk($sformatf("tbl%0d_pulse", i), pulse_a, tbl[i].xp);
            chk($sformatf("tbl%0d_code", i), code_a, tbl[i].xc);
            drive_idle();
        end

        // Forwarded halt: flush at edge 1, pending edges 1..3, halted from edge 4.
        do_reset();
        drive(mk(1, 1, 1, 0, 5'd17, 32'd10, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0));
        tick();
        chk("fwd_flush", flush_a, 1);
        chk("fwd_pend1", pend_a, 1);
        drive_idle();
        for (int k = 2; k <= 8; k++) begin
            tick();
            chk($sformatf("fwd_flush_e%0d", k), flush_a, 0);
            chk($sformatf("fwd_pend_e%0d", k), pend_a, k <= 3);
            chk($sformatf("fwd_halt_e%0d", k), halt_a, k >= 4);
        end

        // Load-use halt: one stall cycle, then MEM/WB resolves.
        do_reset();
        drive(mk(1, 1, 1, 1, 5'd17, 32'hdead, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 32'd0));
        #1 chk("lu_stall1", stall_a, 1);
        tick();
        chk("lu_noflush", flush_a, 0);
        drive(mk(1, 1, 0, 0, 5'd0, 32'd0, 1, 5'd17, 32'd10, 32'd0, 0, 0, 0, 32'd0));
        #1 chk("lu_stall2", stall_a, 0);
        tick();
        chk("lu_flush", flush_a, 1);
        drive_idle();
        for (int k = 0; k < 3; k++) tick();
        chk("lu_halted", halt_a, 1);

        // Saturation on the 2-bit counter instance.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            drive(mk(1, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'(i + 1), 0, 0, 0, 32'd0));
            tick();
            if (pulse_b) pulses++;
            drive_idle();
            tick();
        end
        chk("sat_count", 32'(count_b), 3);
        chk("sat_pulses", pulses, 5);
        chk("sat_count16", 32'(count_a), 5);

        // Reset in the second DRAIN cycle, then a normal syscall.
        do_reset();
        drive(mk(1, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'd10, 0, 0, 0, 32'd0));
        tick();
        drive_idle();
        tick();
        chk("rd_pending", pend_a, 1);
        do_reset();
        drive(mk(1, 1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 32'd7, 0, 0, 0, 32'd0));
        tick();
        chk("rd_pulse", pulse_a, 1);
        chk("rd_code", code_a, 7);
        drive_idle();
        for (int k = 0; k < 5; k++) tick();
        chk("rd_nohalt", halt_a, 0);

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ((halt_at >= 0 && cyc - halt_at > int'(DRAIN) + 2 && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 99) == 0) begin
                do_reset();
            end
            id_ex_valid      = $urandom_range(0, 3) != 0;
            id_ex_is_ecall   = $urandom_range(0, 2) == 0;
            ex_mem_reg_write = $urandom_range(0, 1);
            ex_mem_mem_read  = $urandom_range(0, 3) == 0;
            ex_mem_rd        = ($urandom_range(0, 2) == 0) ? 5'd17 : 5'($urandom_range(0, 31));
            ex_mem_alu_out   = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'($urandom_range(0, 15));
            mem_wb_reg_write = $urandom_range(0, 1);
            mem_wb_rd        = ($urandom_range(0, 2) == 0) ? 5'd17 : 5'($urandom_range(0, 31));
            mem_wb_wdata     = ($urandom_range(0, 3) == 0) ? 32'd10 : 32'($urandom_range(0, 15));
            rf_arg           = ($urandom_range(0, 4) == 0) ? 32'd10 : $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecall_halt_unit.md
# ecall_halt_unit

- Resolves the a7 argument register for an ECALL sitting in ID/EX, using forwarding from EX/MEM and MEM/WB, or the register file.
- Decides between a halt request and an ordinary system call.
- For a halt, sequences flush and pipeline drain before asserting a sticky `is_halted` to the testbench and CPU top.
- Sits beside the hazard unit in the 5-stage pipelined CPU.

## Interface
Parameters:
- XLEN, 32, datapath width
- ARG_REG, 17, register index holding the ECALL code; must be 1..31
- HALT_CODE, 10, a7 value meaning "terminate"
- DRAIN_CYCLES, 3, cycles between halt decision and `is_halted`; must be ≥1
- CNT_W, 16, width of the syscall counter

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-low
- id_ex_valid  in  1  ID/EX holds a live instruction
- id_ex_is_ecall  in  1  ID/EX instruction is ECALL
- ex_mem_reg_write  in  1  EX/MEM writes rd
- ex_mem_mem_read  in  1  EX/MEM is a load
- ex_mem_rd  in  5  EX/MEM destination
- ex_mem_alu_out  in  XLEN  EX/MEM result
- mem_wb_reg_write  in  1  MEM/WB writes rd
- mem_wb_rd  in  5  MEM/WB destination
- mem_wb_wdata  in  XLEN  MEM/WB writeback value
- rf_arg  in  XLEN  register-file read of ARG_REG
- ecall_stall  out  1  hold IF/ID and ID/EX, bubble EX/MEM
- flush_younger  out  1  one-cycle flush of IF/ID and ID/EX
- halt_pending  out  1  in DRAIN
- is_halted  out  1  sticky halt
- syscall_pulse  out  1  one-cycle pulse, non-halt ECALL accepted
- syscall_code  out  XLEN  a7 value of last accepted non-halt ECALL
- syscall_count  out  CNT_W  saturating count of non-halt ECALLs

## Operation
- **ECALL present:** `id_ex_valid & id_ex_is_ecall`. Only evaluated in state IDLE.
- **Resolution priority for a7** (rd==0 never matches):
  - EX/MEM match: `ex_mem_reg_write & ex_mem_rd==ARG_REG`.
    - If `ex_mem_mem_read`, the value is not ready: combinationally assert `ecall_stall`, no decision this cycle.
    - Otherwise use `ex_mem_alu_out`.
  - Else MEM/WB match: use `mem_wb_wdata`.
  - Else use `rf_arg`.
- **Decision**, taken in a cycle with an ECALL present and no stall:
  - Value == HALT_CODE: next edge goes IDLE→DRAIN, `flush_younger`=1 for that cycle, drain counter loaded with DRAIN_CYCLES-1.
  - Otherwise: next edge registers `syscall_pulse`=1 (exactly one cycle), latches `syscall_code`, increments `syscall_count`. The count saturates at all-ones.
- **States:**
  - IDLE: normal operation.
  - DRAIN: `halt_pending`=1; counter decrements each cycle; ECALL inputs ignored. At counter 0 the next edge goes to HALTED.
  - HALTED: `is_halted`=1, `halt_pending`=0. Terminal until reset.
- **Stall rule:** stall only in IDLE; `ecall_stall`=0 in DRAIN/HALTED.
- **Same ECALL across a stall:** it is decided once. The decision cycle is the first non-stalled cycle.
- **Reset mid-DRAIN:** returns to IDLE, counter and all outputs cleared, no halt.

## Timing
- **Reset values:** state IDLE; all outputs 0; `syscall_code`=0; `syscall_count`=0.
- **Combinational:** `ecall_stall` depends on the current-cycle inputs.
- **Registered:** all other outputs.
- **Halt latency:** `is_halted` rises exactly DRAIN_CYCLES+1 edges after the decision cycle.
- **Load-use on a7:** costs exactly one stall cycle. The next cycle resolves via MEM/WB.
- **Same rd in both stages:** when EX/MEM and MEM/WB both target ARG_REG, EX/MEM wins.
- **Syscall pulse latency:** `syscall_pulse` appears 1 edge after the decision cycle.
- **Counter width:** all counter arithmetic is unsigned. The drain counter is $clog2(DRAIN_CYCLES+1) bits.

## Structure
- **Shared package `cpu_pkg`:** opcode constants (including ECALL), the state enum `ecall_state_e` {IDLE, DRAIN, HALTED}, and default ARG_REG/HALT_CODE.
- **Sub-module `arg_forward_mux`:** combinational a7 resolution. Outputs the value plus a `not_ready` flag; reusable for rs1/rs2 forwarding.
- **FSM, counters and output registers:** live in `ecall_halt_unit`.

## Test plan
- **Forwarded halt:** ECALL in ID/EX, EX/MEM writes x17 with alu_out=10 (non-load).
  - Required: `flush_younger` pulse next cycle, `halt_pending` for 3 cycles, `is_halted`=1 at edge 4, then held.
- **Load-use halt:** EX/MEM is a load to x17, value 10.
  - Required: `ecall_stall`=1 for one cycle.
  - Next cycle MEM/WB wdata=10 resolves, and the halt sequence proceeds.
- **Priority and non-halt path:** EX/MEM x17=5 and MEM/WB x17=10 at the same time.
  - Required: EX/MEM wins, no halt, `syscall_pulse` once, `syscall_code`=5, `syscall_count`=1.
- **Register-file path and x0:** no forwarding match, `rf_arg`=10 → halt.
  - Repeat with ex_mem_rd=0, reg_write=1, alu_out=10 and rf_arg=4: no halt, code=4.
- **Saturation:** CNT_W=2, issue 5 non-halt ECALLs.
  - Required: `syscall_count` stops at 3, 5 pulses observed.
- **Reset during DRAIN:** assert reset at the 2nd DRAIN cycle.
  - Required: all outputs 0 immediately (async).
  - After release: IDLE; a new ECALL with a7=7 produces a normal syscall.
